// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: address width, next-PC select codes,
// NOP word and fetch progress states.
package cpu_pkg;

  localparam int ADDR_W = 11;

  localparam logic [1:0] PC_INC   = 2'b00;
  localparam logic [1:0] PC_START = 2'b01;
  localparam logic [1:0] PC_BR    = 2'b10;
  localparam logic [1:0] PC_HOLD  = 2'b11;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ADDR_WAIT = 2'd1,
    ST_DATA_RDY  = 2'd2,
    ST_CAPTURED  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register with next-PC select, wrap-around increment and
// a flag telling whether the coming edge really moves the PC.
module pc_reg
  import cpu_pkg::*;
#(
  parameter int START_PC = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [1:0]        i_sel,
  input  logic [ADDR_W-1:0] i_br_target,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_changed
);

  localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(START_PC);
  localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;

  always_comb begin
    w_pc_next = r_pc;
    if (i_load) begin
      case (i_sel)
        PC_INC:   w_pc_next = r_pc + ONE;
        PC_START: w_pc_next = START_ADDR;
        PC_BR:    w_pc_next = i_br_target;
        default:  w_pc_next = r_pc;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc <= START_ADDR;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // Reloading the same address is not a change, so the RAM read stays valid.
  assign o_changed = (w_pc_next != r_pc);
  assign o_pc      = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, instruction register and RAM read-latency
// tracking that flags an instruction captured before its data settled.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int START_PC = 0,
  parameter int RAM_LAT  = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load_pc,
  input  logic [1:0]        i_sel_pc,
  input  logic [ADDR_W-1:0] i_br_target,
  input  logic              i_load_ir,
  input  logic [31:0]       i_ram_rd_data1,
  output logic [ADDR_W-1:0] o_ram_addr1,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc_ir,
  output logic [31:0]       o_instr,
  output logic              o_instr_valid,
  output logic              o_fetch_err
);

  localparam logic [1:0] LAT_MAX = 2'(RAM_LAT);

  logic [ADDR_W-1:0] w_pc;
  logic              w_pc_changed;
  logic              w_data_ok;
  logic [1:0]        w_lat_next;
  logic [1:0]        r_lat_cnt;
  fetch_state_t      r_state;
  fetch_state_t      w_state_next;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_pc_ir;
  logic              r_instr_valid;
  logic              r_fetch_err;

  pc_reg #(
    .START_PC (START_PC)
  ) u_pc_reg (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_load      (i_load_pc),
    .i_sel       (i_sel_pc),
    .i_br_target (i_br_target),
    .o_pc        (w_pc),
    .o_changed   (w_pc_changed)
  );

  assign w_data_ok = (r_lat_cnt == LAT_MAX);

  always_comb begin
    w_lat_next = r_lat_cnt;
    if (w_pc_changed) begin
      w_lat_next = 2'd0;
    end else if (!w_data_ok) begin
      w_lat_next = r_lat_cnt + 2'd1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_load_pc) w_state_next = ST_ADDR_WAIT;
      end
      ST_ADDR_WAIT: begin
        if (w_lat_next == LAT_MAX) w_state_next = ST_DATA_RDY;
      end
      ST_DATA_RDY: begin
        if (w_pc_changed)   w_state_next = ST_ADDR_WAIT;
        else if (i_load_ir) w_state_next = ST_CAPTURED;
      end
      ST_CAPTURED: begin
        if (w_pc_changed) w_state_next = ST_ADDR_WAIT;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_lat_cnt <= 2'd0;
    end else begin
      r_state   <= w_state_next;
      r_lat_cnt <= w_lat_next;
    end
  end

  // Capture samples the pre-update PC and latency; a stale capture still loads.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_instr       <= NOP_WORD;
      r_pc_ir       <= '0;
      r_instr_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
    end else if (i_load_ir) begin
      r_instr       <= i_ram_rd_data1;
      r_pc_ir       <= w_pc;
      r_instr_valid <= w_data_ok;
      if (!w_data_ok) r_fetch_err <= 1'b1;
    end
  end

  assign o_ram_addr1   = w_pc;
  assign o_pc          = w_pc;
  assign o_pc_ir       = r_pc_ir;
  assign o_instr       = r_instr;
  assign o_instr_valid = r_instr_valid;
  assign o_fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit: a driver steps a behavioural
// model and queues expected outputs, a monitor compares after each edge.
module tb_fetch_unit;

  localparam int ADDR_W   = 11;
  localparam int DEPTH    = 2048;
  localparam int START_PC = 0;
  localparam int RAM_LAT  = 2;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pcIr;
    logic [31:0]       instr;
    logic              valid;
    logic              err;
  } expT;

  logic              clk = 1'b0;
  logic              rstN;
  logic              loadPc;
  logic [1:0]        selPc;
  logic [ADDR_W-1:0] brTarget;
  logic              loadIr;
  logic [31:0]       ramRdData;
  logic [ADDR_W-1:0] ramAddr;
  logic [ADDR_W-1:0] pcOut;
  logic [ADDR_W-1:0] pcIrOut;
  logic [31:0]       instrOut;
  logic              validOut;
  logic              errOut;

  logic [31:0] mem [0:DEPTH-1];
  expT         expQ[$];
  int          compared   = 0;
  int          mismatched = 0;

  // Reference state: stableCycles counts edges since the PC last moved.
  int          mPc;
  int          mPcIr;
  logic [31:0] mInstr;
  logic        mValid;
  logic        mErr;
  int          stableCycles;

  always #5 clk = ~clk;

  assign ramRdData = mem[ramAddr];

  fetch_unit #(
    .START_PC (START_PC),
    .RAM_LAT  (RAM_LAT)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rstN),
    .i_load_pc      (loadPc),
    .i_sel_pc       (selPc),
    .i_br_target    (brTarget),
    .i_load_ir      (loadIr),
    .i_ram_rd_data1 (ramRdData),
    .o_ram_addr1    (ramAddr),
    .o_pc           (pcOut),
    .o_pc_ir        (pcIrOut),
    .o_instr        (instrOut),
    .o_instr_valid  (validOut),
    .o_fetch_err    (errOut)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPc          = START_PC;
    mPcIr        = 0;
    mInstr       = 32'h0;
    mValid       = 1'b0;
    mErr         = 1'b0;
    stableCycles = 0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".pc"},    {21'd0, pcOut},    START_PC);
    checkOutput({tag, ".addr"},  {21'd0, ramAddr},  START_PC);
    checkOutput({tag, ".pcIr"},  {21'd0, pcIrOut},  32'd0);
    checkOutput({tag, ".instr"}, instrOut,          32'd0);
    checkOutput({tag, ".valid"}, {31'd0, validOut}, 32'd0);
    checkOutput({tag, ".err"},   {31'd0, errOut},   32'd0);
  endtask

  // One clock edge of the reference model, driven by the inputs now applied.
  task automatic stepModel();
    int   nextPc;
    logic dataOk;
    expT  e;
    nextPc = mPc;
    if (loadPc) begin
      case (selPc)
        2'b00:   nextPc = (mPc + 1) % DEPTH;
        2'b01:   nextPc = START_PC;
        2'b10:   nextPc = int'(brTarget);
        default: nextPc = mPc;
      endcase
    end
    dataOk = (stableCycles >= RAM_LAT);
    if (loadIr) begin
      mInstr = mem[mPc];
      mPcIr  = mPc;
      mValid = dataOk;
      if (!dataOk) mErr = 1'b1;
    end
    if (nextPc != mPc) stableCycles = 0;
    else               stableCycles++;
    mPc = nextPc;
    e.pc    = ADDR_W'(mPc);
    e.pcIr  = ADDR_W'(mPcIr);
    e.instr = mInstr;
    e.valid = mValid;
    e.err   = mErr;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic lp, input logic [1:0] sel,
                               input logic [ADDR_W-1:0] br, input logic li);
    @(negedge clk);
    loadPc   = lp;
    selPc    = sel;
    brTarget = br;
    loadIr   = li;
    stepModel();
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rstN     = 1'b1;
    loadPc   = 1'b0;
    selPc    = 2'b11;
    brTarget = '0;
    loadIr   = 1'b0;
    stepModel();
  endtask

  // Monitor: pops one expectation per edge once the driver has queued it.
  initial begin
    expT e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("pc",    {21'd0, pcOut},    {21'd0, e.pc});
        checkOutput("addr",  {21'd0, ramAddr},  {21'd0, e.pc});
        checkOutput("pcIr",  {21'd0, pcIrOut},  {21'd0, e.pcIr});
        checkOutput("instr", instrOut,          e.instr);
        checkOutput("valid", {31'd0, validOut}, {31'd0, e.valid});
        checkOutput("err",   {31'd0, errOut},   {31'd0, e.err});
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[0] = 32'hE3A01005;
    rstN = 1'b0; loadPc = 1'b0; selPc = 2'b11; brTarget = '0; loadIr = 1'b0;
    modelReset();
    #3;
    checkResetState("reset");
    repeat (2) @(posedge clk);
    releaseReset();

    // Normal fetch loop from START_PC
    applyStimulus(1'b1, 2'b01, '0, 1'b0);
    applyStimulus(1'b0, 2'b11, '0, 1'b0);
    applyStimulus(1'b0, 2'b11, '0, 1'b0);
    applyStimulus(1'b0, 2'b11, '0, 1'b1);
    applyStimulus(1'b1, 2'b00, '0, 1'b0);

    // Wrap at the top of the address space, then branch
    applyStimulus(1'b1, 2'b10, 11'd2047, 1'b0);
    applyStimulus(1'b1, 2'b00, '0, 1'b0);
    applyStimulus(1'b1, 2'b10, 11'h123, 1'b0);

    // Simultaneous load_pc and load_ir, then holds keep the latency counting
    applyStimulus(1'b1, 2'b10, 11'd5, 1'b0);
    applyStimulus(1'b0, 2'b11, '0, 1'b0);
    applyStimulus(1'b0, 2'b11, '0, 1'b0);
    applyStimulus(1'b1, 2'b00, '0, 1'b1);
    applyStimulus(1'b1, 2'b11, '0, 1'b0);
    applyStimulus(1'b1, 2'b11, '0, 1'b0);
    applyStimulus(1'b0, 2'b11, '0, 1'b1);

    // Early capture, then a good fetch that must leave the error sticky
    applyStimulus(1'b1, 2'b10, 11'h040, 1'b0);
    applyStimulus(1'b0, 2'b11, '0, 1'b1);
    applyStimulus(1'b0, 2'b11, '0, 1'b0);
    applyStimulus(1'b0, 2'b11, '0, 1'b1);

    // Asynchronous reset between load_pc and load_ir
    applyStimulus(1'b1, 2'b10, 11'h077, 1'b0);
    @(posedge clk);
    #2;
    rstN = 1'b0;
    loadIr = 1'b1;
    #1;
    modelReset();
    checkResetState("midReset");
    repeat (2) @(posedge clk);
    releaseReset();

    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 9) < 3), 2'($urandom_range(0, 3)),
                    ADDR_W'($urandom), ($urandom_range(0, 9) < 3));
    end
    applyStimulus(1'b0, 2'b11, '0, 1'b0);

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
    #2;
    if (expQ.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
